// File: rtl/video_timing_detector.sv
// video_timing_detector: pixel-clock-domain sink that measures an hsync/vsync/de
// stream. It reports line and frame sizes, locks to a stable mode, and generates
// active-area pixel coordinates.
// Optional feature: define VTD_MODE_CHECK_EN to qualify mode_ok against the
// expected-mode parameters H_TOTAL/H_ACTIVE_PIXEL/V_TOTAL/V_ACTIVE_LINE.
module video_timing_detector #(
  parameter int H_WIDTH        = 11,
  parameter int V_WIDTH        = 10,
  parameter int LOCK_FRAMES    = 2,
  parameter int H_TOTAL        = 800,
  parameter int H_ACTIVE_PIXEL = 640,
  parameter int V_TOTAL        = 525,
  parameter int V_ACTIVE_LINE  = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               de,
  output logic [H_WIDTH-1:0] h_total_m,
  output logic [H_WIDTH-1:0] h_active_m,
  output logic [V_WIDTH-1:0] v_total_m,
  output logic [V_WIDTH-1:0] v_active_m,
  output logic               locked,
  output logic               timing_changed,
  output logic               frame_start,
  output logic [H_WIDTH-1:0] pix_x,
  output logic [V_WIDTH-1:0] pix_y,
  output logic               pix_valid,
  output logic               mode_ok
);

`ifdef VTD_MODE_CHECK_EN
  localparam bit MODE_CHECK = 1'b1;
`else
  localparam bit MODE_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [H_WIDTH-1:0] H_MAX      = {H_WIDTH{1'b1}};
  localparam logic [V_WIDTH-1:0] V_MAX      = {V_WIDTH{1'b1}};
  localparam logic [3:0]         LOCK_MATCH = 4'(LOCK_FRAMES - 1);

  function automatic logic [H_WIDTH-1:0] inc_h(input logic [H_WIDTH-1:0] v);
    return (v == H_MAX) ? v : v + H_WIDTH'(1);
  endfunction

  function automatic logic [V_WIDTH-1:0] inc_v(input logic [V_WIDTH-1:0] v);
    return (v == V_MAX) ? v : v + V_WIDTH'(1);
  endfunction

  logic hs_q, vs_q, de_q, hs_qq, vs_qq, de_qq;
  logic hs_rise, vs_rise, de_fall, timeout, rec_same;
  logic [H_WIDTH-1:0] lc_q, lc_d, line_len_q, line_len_d, run_q, run_d;
  logic [H_WIDTH-1:0] line_act_q, line_act_d, pix_x_q, pix_x_d;
  logic [H_WIDTH-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
  logic [V_WIDTH-1:0] lines_q, lines_d, lines_inc, act_q, act_d, act_inc;
  logic [V_WIDTH-1:0] row_q, row_d, pix_y_q, pix_y_d;
  logic [V_WIDTH-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
  logic               seen_q, seen_d, pix_valid_q, pix_valid_d, fs_q, fs_d;
  logic               locked_q, locked_d, tc_q, tc_d, mode_ok_q, mode_ok_d;
  logic               have_prev_q, have_prev_d;
  logic [3:0]         match_q, match_d, match_n;
  state_t             state_q, state_d;

  assign hs_rise = hs_q & ~hs_qq;
  assign vs_rise = vs_q & ~vs_qq;
  assign de_fall = ~de_q & de_qq;
  // A stuck line counter means hsync has vanished; a coincident hsync rise rescues it.
  assign timeout = (lc_q == H_MAX) && !hs_rise;

  // Measurement counters, coordinates and the SEARCH/MEASURE/LOCKED decision.
  always_comb begin
    lc_d        = hs_rise ? '0 : inc_h(lc_q);
    line_len_d  = hs_rise ? lc_q + H_WIDTH'(1) : line_len_q;
    run_d       = de_q ? inc_h(run_q) : '0;
    line_act_d  = de_fall ? run_q : line_act_q;
    seen_d      = hs_rise ? de_q : (seen_q | de_q);
    // The hsync coinciding with vsync closes the last line of the ending frame.
    lines_inc   = hs_rise ? inc_v(lines_q) : lines_q;
    act_inc     = (hs_rise && seen_q) ? inc_v(act_q) : act_q;
    lines_d     = vs_rise ? '0 : lines_inc;
    act_d       = vs_rise ? '0 : act_inc;
    row_d       = vs_rise ? '0 : (de_fall ? inc_v(row_q) : row_q);
    pix_valid_d = de_q;
    pix_x_d     = de_q ? run_q : pix_x_q;
    pix_y_d     = de_q ? row_q : pix_y_q;
    fs_d        = vs_rise;

    rec_same    = have_prev_q && (line_len_d == h_total_q) && (line_act_d == h_active_q) &&
                  (lines_inc == v_total_q) && (act_inc == v_active_q);

    state_d     = state_q;
    match_d     = match_q;
    match_n     = '0;
    have_prev_d = have_prev_q;
    locked_d    = locked_q;
    tc_d        = 1'b0;
    h_total_d   = h_total_q;
    h_active_d  = h_active_q;
    v_total_d   = v_total_q;
    v_active_d  = v_active_q;

    if (timeout) begin
      tc_d        = (state_q == LOCKED);
      state_d     = SEARCH;
      locked_d    = 1'b0;
      match_d     = '0;
      // Forget the old record so a resumed stream must prove itself again.
      have_prev_d = 1'b0;
    end else if (vs_rise) begin
      case (state_q)
        SEARCH: begin
          state_d = MEASURE;
          match_d = '0;
        end
        MEASURE: begin
          match_n     = rec_same ? match_q + 4'd1 : 4'd0;
          match_d     = match_n;
          have_prev_d = 1'b1;
          h_total_d   = line_len_d;
          h_active_d  = line_act_d;
          v_total_d   = lines_inc;
          v_active_d  = act_inc;
          if (match_n == LOCK_MATCH) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end
        end
        LOCKED: begin
          if (!rec_same) begin
            state_d  = MEASURE;
            locked_d = 1'b0;
            tc_d     = 1'b1;
            match_d  = '0;
          end
        end
        default: begin
          state_d  = SEARCH;
          locked_d = 1'b0;
          match_d  = '0;
        end
      endcase
    end

    mode_ok_d = locked_d && (!MODE_CHECK ||
                ((h_total_d == H_WIDTH'(H_TOTAL)) && (h_active_d == H_WIDTH'(H_ACTIVE_PIXEL)) &&
                 (v_total_d == V_WIDTH'(V_TOTAL)) && (v_active_d == V_WIDTH'(V_ACTIVE_LINE))));
  end

  // All state, including the FSM and registered outputs, clears asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {hs_q, vs_q, de_q, hs_qq, vs_qq, de_qq} <= '0;
      lc_q <= '0; line_len_q <= '0; run_q <= '0; line_act_q <= '0; seen_q <= 1'b0;
      lines_q <= '0; act_q <= '0; row_q <= '0;
      pix_x_q <= '0; pix_y_q <= '0; pix_valid_q <= 1'b0; fs_q <= 1'b0;
      h_total_q <= '0; h_active_q <= '0; v_total_q <= '0; v_active_q <= '0;
      state_q <= SEARCH; match_q <= '0; have_prev_q <= 1'b0;
      locked_q <= 1'b0; tc_q <= 1'b0; mode_ok_q <= 1'b0;
    end else begin
      hs_q <= hsync; vs_q <= vsync; de_q <= de;
      hs_qq <= hs_q; vs_qq <= vs_q; de_qq <= de_q;
      lc_q <= lc_d; line_len_q <= line_len_d; run_q <= run_d; line_act_q <= line_act_d;
      seen_q <= seen_d; lines_q <= lines_d; act_q <= act_d; row_q <= row_d;
      pix_x_q <= pix_x_d; pix_y_q <= pix_y_d; pix_valid_q <= pix_valid_d; fs_q <= fs_d;
      h_total_q <= h_total_d; h_active_q <= h_active_d;
      v_total_q <= v_total_d; v_active_q <= v_active_d;
      state_q <= state_d; match_q <= match_d; have_prev_q <= have_prev_d;
      locked_q <= locked_d; tc_q <= tc_d; mode_ok_q <= mode_ok_d;
    end
  end

  assign h_total_m      = h_total_q;
  assign h_active_m     = h_active_q;
  assign v_total_m      = v_total_q;
  assign v_active_m     = v_active_q;
  assign locked         = locked_q;
  assign timing_changed = tc_q;
  assign frame_start    = fs_q;
  assign pix_x          = pix_x_q;
  assign pix_y          = pix_y_q;
  assign pix_valid      = pix_valid_q;
  assign mode_ok        = mode_ok_q;

endmodule

// File: tb/tb_video_timing_detector.sv
// Testbench for video_timing_detector: small synthetic video modes (fixed and
// random) checked against a frame-level reference model.
module tb_video_timing_detector;
  localparam int HW = 11, VW = 10, LF = 2;
  localparam int A_HT = 40, A_HA = 24, A_VT = 12, A_VA = 6;
  localparam int HS = 4, HB = 6, VS = 2, VB = 3;

  logic clk = 1'b0, rst = 1'b0, hsync = 1'b0, vsync = 1'b0, de = 1'b0;
  logic [HW-1:0] h_total_m, h_active_m, pix_x;
  logic [VW-1:0] v_total_m, v_active_m, pix_y;
  logic locked, timing_changed, frame_start, pix_valid, mode_ok;

  always #5 clk = ~clk;

  video_timing_detector #(
    .H_WIDTH(HW), .V_WIDTH(VW), .LOCK_FRAMES(LF),
    .H_TOTAL(A_HT), .H_ACTIVE_PIXEL(A_HA), .V_TOTAL(A_VT), .V_ACTIVE_LINE(A_VA)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .de(de),
    .h_total_m(h_total_m), .h_active_m(h_active_m), .v_total_m(v_total_m),
    .v_active_m(v_active_m), .locked(locked), .timing_changed(timing_changed),
    .frame_start(frame_start), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .mode_ok(mode_ok)
  );

  typedef struct { int ht; int ha; int vt; int va; } rec_t;

  int checks = 0, errors = 0;
  // Frame-level reference: 0 = searching, 1 = measuring, 2 = locked.
  int   m_state, m_match;
  bit   m_prev_valid, m_locked, m_tc;
  rec_t m_out, cur_rec, last_rec;
  rec_t q_rec[$];
  // Two-deep history of driven pixels: outputs show inputs from two clocks back.
  bit   hist_de[2], hist_vr[2], hist_ok[2];
  int   hist_x[2], hist_y[2];
  bit   prev_vs, coord_ok, lock_chk;
  int   tc_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit same(input rec_t a, input rec_t b);
    return a.ht == b.ht && a.ha == b.ha && a.vt == b.vt && a.va == b.va;
  endfunction

  function automatic bit exp_mode_ok();
`ifdef VTD_MODE_CHECK_EN
    return m_locked && m_out.ht == A_HT && m_out.ha == A_HA && m_out.vt == A_VT && m_out.va == A_VA;
`else
    return m_locked;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0; m_match = 0; m_prev_valid = 0; m_locked = 0; m_tc = 0;
    m_out = '{0, 0, 0, 0};
    q_rec.delete();
    for (int i = 0; i < 2; i++) begin
      hist_de[i] = 0; hist_vr[i] = 0; hist_ok[i] = 0; hist_x[i] = 0; hist_y[i] = 0;
    end
    prev_vs = 0; coord_ok = 0;
  endtask

  // One closed frame record arrives at a vsync rise.
  task automatic model_vsync(input rec_t r);
    m_tc = 0;
    case (m_state)
      0: begin m_state = 1; m_match = 0; end
      1: begin
        m_match = (m_prev_valid && same(r, m_out)) ? m_match + 1 : 0;
        m_out = r; m_prev_valid = 1;
        if (m_match == LF - 1) begin m_state = 2; m_locked = 1; end
      end
      default: begin
        if (!same(r, m_out)) begin m_locked = 0; m_tc = 1; m_state = 1; m_match = 0; end
      end
    endcase
  endtask

  task automatic step(input bit h, input bit v, input bit d, input int x, input int y);
    rec_t r;
    bit fs_exp, vr;
    @(posedge clk); #1;
    fs_exp = hist_vr[1];
    check("frame_start", frame_start, fs_exp);
    if (fs_exp && q_rec.size() > 0) begin
      r = q_rec.pop_front();
      model_vsync(r);
      if (lock_chk) begin
        check("h_total_m", h_total_m, m_out.ht);
        check("h_active_m", h_active_m, m_out.ha);
        check("v_total_m", v_total_m, m_out.vt);
        check("v_active_m", v_active_m, m_out.va);
      end
    end
    if (lock_chk) begin
      check("locked", locked, m_locked);
      check("timing_changed", timing_changed, fs_exp && m_tc);
      check("mode_ok", mode_ok, exp_mode_ok());
    end else if (timing_changed) begin
      tc_pulses++;
    end
    check("pix_valid", pix_valid, hist_de[1]);
    if (hist_de[1] && hist_ok[1]) begin
      check("pix_x", pix_x, hist_x[1]);
      check("pix_y", pix_y, hist_y[1]);
    end
    vr = v && !prev_vs;
    if (vr) begin
      q_rec.push_back(last_rec);
      last_rec = cur_rec;
      coord_ok = 1;
    end
    prev_vs = v;
    hist_de[1] = hist_de[0]; hist_vr[1] = hist_vr[0]; hist_ok[1] = hist_ok[0];
    hist_x[1] = hist_x[0]; hist_y[1] = hist_y[0];
    hist_de[0] = d; hist_vr[0] = vr; hist_ok[0] = coord_ok; hist_x[0] = x; hist_y[0] = y;
    hsync = h; vsync = v; de = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic frame(input int ht, input int ha, input int vt, input int va, input int stop_line);
    cur_rec = '{ht, ha, vt, va};
    for (int l = 0; l < vt; l++)
      for (int p = 0; p < ht; p++) begin
        if (l == stop_line && p == 10) return;
        step(p < HS, l < VS, (p >= HB) && (p < HB + ha) && (l >= VB) && (l < VB + va), p - HB, l - VB);
      end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_h_total_m"}, h_total_m, 0);
    check({tag, "_h_active_m"}, h_active_m, 0);
    check({tag, "_v_total_m"}, v_total_m, 0);
    check({tag, "_v_active_m"}, v_active_m, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_timing_changed"}, timing_changed, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_pix_x"}, pix_x, 0);
    check({tag, "_pix_y"}, pix_y, 0);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_mode_ok"}, mode_ok, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ht, ha, vt, va;
    model_reset();
    lock_chk = 1; tc_pulses = 0;
    cur_rec = '{0, 0, 0, 0}; last_rec = cur_rec;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    idle(4);

    // Base mode: lock on the third vsync rise.
    repeat (4) frame(A_HT, A_HA, A_VT, A_VA, -1);
    check("locked_mode_a", locked, 1);
    check("h_total_mode_a", h_total_m, A_HT);

    // Random modes, each long enough to unlock and relock.
    for (int k = 0; k < 3; k++) begin
      ht = $urandom_range(48, 34);
      ha = $urandom_range(ht - HB - 2, 8);
      vt = $urandom_range(16, 10);
      va = $urandom_range(vt - VB - 2, 3);
      repeat (4) frame(ht, ha, vt, va, -1);
      check("locked_random", locked, 1);
      check("h_active_random", h_active_m, ha);
      check("v_active_random", v_active_m, va);
    end

    // Back to the base mode, then stretch the line by ten clocks.
    repeat (4) frame(A_HT, A_HA, A_VT, A_VA, -1);
    check("locked_before_stretch", locked, 1);
    repeat (4) frame(A_HT + 10, A_HA, A_VT, A_VA, -1);
    check("locked_stretched", locked, 1);
    check("h_total_stretched", h_total_m, A_HT + 10);

    // hsync disappears long enough for the line counter to saturate.
    lock_chk = 0; tc_pulses = 0;
    idle(2100);
    check("timeout_pulses", tc_pulses, 1);
    check("locked_after_timeout", locked, 0);
    m_state = 0; m_locked = 0; m_match = 0; m_prev_valid = 0;
    lock_chk = 1;
    repeat (4) frame(A_HT, A_HA, A_VT, A_VA, -1);
    check("locked_after_resume", locked, 1);

    // Reset in the middle of a frame while locked.
    frame(A_HT, A_HA, A_VT, A_VA, A_VT - 2);
    check("locked_pre_reset", locked, 1);
    rst = 1'b0; hsync = 1'b0; vsync = 1'b0; de = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    idle(5);
    repeat (4) frame(A_HT, A_HA, A_VT, A_VA, -1);
    check("locked_after_reset", locked, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_timing_detector.md
# video_timing_detector

Sink-side counterpart of the HDMI timing generator. Runs in the pixel clock domain, takes a DVI-style `hsync`/`vsync`/`de` stream (from the decoded TMDS receive path or a loopback of our own generator), and measures:
- horizontal and vertical total and active sizes;
- lock to a stable mode;
- per-pixel active-area coordinates for downstream pixel processing.

## Interface
Parameters:
- `H_WIDTH`, 11: width of horizontal counters/measurements.
- `V_WIDTH`, 10: width of vertical counters/measurements.
- `LOCK_FRAMES`, 2: consecutive identical frames required to lock (1..15).
- `H_TOTAL`, `H_ACTIVE_PIXEL`, 800, 640: expected horizontal timing (used only with `VTD_MODE_CHECK_EN`).
- `V_TOTAL`, `V_ACTIVE_LINE`, 525, 480: expected vertical timing (used only with `VTD_MODE_CHECK_EN`).

Ports:
- `clk`  in  1  pixel clock; single clock domain.
- `rst`  in  1  reset, asynchronous and active-low.
- `hsync`, `vsync`, `de`  in  1 each  video timing, active-high.
- `h_total_m`  out  H_WIDTH  measured clocks per line.
- `h_active_m`  out  H_WIDTH  measured `de` run length per line.
- `v_total_m`  out  V_WIDTH  measured lines per frame.
- `v_active_m`  out  V_WIDTH  measured lines containing `de` per frame.
- `locked`  out  1  mode stable.
- `timing_changed`  out  1  one-cycle pulse when lock is lost.
- `frame_start`  out  1  one-cycle pulse on each vsync rising edge.
- `pix_x`  out  H_WIDTH  active column.
- `pix_y`  out  V_WIDTH  active row.
- `pix_valid`  out  1  `pix_x`/`pix_y` valid.
- `mode_ok`  out  1  locked and matches expected mode.

## Operation
- Input stage: `hsync`, `de` and `vsync` are registered once (stage q). Rising and falling edges are detected against a second register.
- Line counter `lc` (H_WIDTH bits):
  - On an hsync rise: `lc` <= 0 and the line length is captured as `lc+1`.
  - Otherwise `lc` increments, saturating at all-ones.
  - Saturation means timeout: force state SEARCH and clear `locked`.
- `de` run counter: increments while `de_q`; its value is captured on the `de` falling edge as the line active length.
- Frame counters:
  - Count hsync rises between vsync rises.
  - Count lines with at least one `de` cycle.
  - Both saturate at all-ones.
- Frame record `{line_len, line_active, lines, active_lines}`: `line_len`/`line_active` are taken from the last line of the frame. The record closes on each vsync rise.
- FSM states SEARCH, MEASURE, LOCKED:
  - SEARCH: at the first vsync rise, clear the frame counters and go to MEASURE.
  - MEASURE: at each vsync rise, compare the new record with the previous one.
    - Equal: increment the match count.
    - Different: reset the match count to 0.
    - Either way, store the record and drive it to the `*_m` outputs.
    - When the match count reaches `LOCK_FRAMES-1`, go to LOCKED with `locked`=1.
  - LOCKED: the `*_m` outputs are frozen. On a vsync rise with a differing record, or on a timeout:
    - `locked`=0 and `timing_changed`=1 for one cycle;
    - next state MEASURE (differing record) or SEARCH (timeout); the match count is cleared.
- Coordinates: `pix_x` counts `de_q` cycles within the line (0 at the first `de`). `pix_y` counts active lines since vsync (0 on the first active line), advancing on the `de` falling edge. `pix_valid` = registered `de_q`. Coordinates are produced regardless of lock.
- Simultaneous hsync and vsync rise: the hsync line count is included before the frame closes; the line is counted in the ending frame.
- `de` high across vsync: the run continues and `pix_y` resets; there is no error flag.

## Timing
- Reset values: all outputs 0; FSM = SEARCH; all counters 0.
- `pix_valid`/`pix_x`/`pix_y`: 2 clocks after the input `de`.
- `frame_start`: asserted 2 clocks after the input vsync rise.
- `*_m`, `locked`, `timing_changed`: update in the same cycle as `frame_start`.
- Lock latency: first vsync rise + `LOCK_FRAMES` further frames.
- Reset asserted mid-frame: all state clears immediately; after release, detection restarts from SEARCH.

## Configuration
- `VTD_MODE_CHECK_EN` defined: `mode_ok` = `locked` and all four measurements equal `H_TOTAL`, `H_ACTIVE_PIXEL`, `V_TOTAL`, `V_ACTIVE_LINE`. It is registered and updates with `locked`.
- Not defined: `mode_ok` = `locked`; the expected-mode parameters are unused.

## Test plan
- 640x480 stream (800/640/525/480, hsync 96, vsync 2), `LOCK_FRAMES`=2 -> `locked` rises at the third vsync edge. Outputs `h_total_m`=800, `h_active_m`=640, `v_total_m`=525, `v_active_m`=480.
- Same stream, check coordinates -> first `pix_valid` has `pix_x`=0, `pix_y`=0. The last pixel has 639/479. `pix_valid` lags `de` by 2 clocks.
- Locked, then switch to `h_total`=810 -> at the next vsync rise, one-cycle `timing_changed`, `locked`=0. Relock two frames later with `h_total_m`=810.
- Locked, then hold hsync low for 2048 clocks -> `locked`=0, `timing_changed` pulse, FSM SEARCH. Resuming the stream relocks after 3 vsync rises.
- Assert `rst` mid-frame while locked -> all outputs 0 asynchronously. After release, no `frame_start` before the next vsync rise.
- `VTD_MODE_CHECK_EN` defined: the 640x480 stream gives `mode_ok`=1; an 800x600 stream locks with `mode_ok`=0.
